// File: rtl/core_if_fetch.sv
// Instruction-fetch stage: credit-based sequential fetch, in-order response buffer
// feeding decode, and redirect handling that drops responses issued before a flush.
module core_if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_ifu_req_valid,
  input  logic        i_ifu_req_ready,
  output logic [31:0] o_ifu_req_addr,
  input  logic        i_ifu_rsp_valid,
  input  logic [31:0] i_ifu_rsp_data,
  input  logic        i_ifu_rsp_err,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  output logic        o_ir_valid,
  input  logic        i_ir_ready,
  output logic [31:0] o_ir_inst,
  output logic [31:0] o_ir_pc,
  output logic        o_ir_err
);

  localparam int unsigned   PW      = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  logic [31:2]      pc_w;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop;

  logic [31:0]      ent_pc   [FIFO_DEPTH];
  logic [31:0]      ent_inst [FIFO_DEPTH];
  logic             ent_err  [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, rd_next;

  logic [31:0]      inflight_pc [FIFO_DEPTH];
  logic [PW-1:0]    if_rd, if_wr;

  logic [CNT_W:0]   used;
  logic             credit, req_hs, push, pop;
  logic [31:0]      rsp_pc;
  logic             flush_pc_unused;

  always_comb begin
    used            = {1'b0, outstanding} + {1'b0, count};
    credit          = used < DEPTH_C;
    o_ifu_req_valid = !i_rst && !i_flush && credit;
    o_ifu_req_addr  = {pc_w, 2'b00};
    req_hs          = o_ifu_req_valid && i_ifu_req_ready;
    o_ir_valid      = count != '0;
    push            = i_ifu_rsp_valid && (drop == '0) && !i_flush;
    pop             = o_ir_valid && i_ir_ready && !i_flush;
    rsp_pc          = inflight_pc[if_rd];
    rd_next         = rd_ptr + PW'(1);
    flush_pc_unused = ^i_flush_pc[1:0];
  end

  // Payload storage carries no reset; validity is tracked by the counters/pointers.
  always_ff @(posedge i_clk) begin
    if (req_hs)
      inflight_pc[if_wr] <= o_ifu_req_addr;
    if (push) begin
      ent_pc[wr_ptr]   <= rsp_pc;
      ent_inst[wr_ptr] <= i_ifu_rsp_data;
      ent_err[wr_ptr]  <= i_ifu_rsp_err;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_w        <= RESET_PC[31:2];
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      if_rd       <= '0;
      if_wr       <= '0;
      o_ir_inst   <= '0;
      o_ir_pc     <= '0;
      o_ir_err    <= 1'b0;
    end else begin
      outstanding <= outstanding + CNT_W'(req_hs) - CNT_W'(i_ifu_rsp_valid);
      if (req_hs)
        if_wr <= if_wr + PW'(1);
      // In-flight PCs are popped by every response, including dropped ones.
      if (i_ifu_rsp_valid)
        if_rd <= if_rd + PW'(1);

      if (i_flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        drop   <= outstanding - CNT_W'(i_ifu_rsp_valid);
        pc_w   <= i_flush_pc[31:2];
      end else begin
        if (req_hs)
          pc_w <= pc_w + 30'd1;
        if (i_ifu_rsp_valid && (drop != '0))
          drop <= drop - CNT_W'(1);
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop)
          rd_ptr <= rd_next;
        count <= count + CNT_W'(push) - CNT_W'(pop);

        // Head follows the next stored entry, or the incoming response when it
        // becomes the only entry; otherwise it holds.
        if (pop && (count > CNT_W'(1))) begin
          o_ir_pc   <= ent_pc[rd_next];
          o_ir_inst <= ent_inst[rd_next];
          o_ir_err  <= ent_err[rd_next];
        end else if (push && ((count == '0) || (pop && (count == CNT_W'(1))))) begin
          o_ir_pc   <= rsp_pc;
          o_ir_inst <= i_ifu_rsp_data;
          o_ir_err  <= i_ifu_rsp_err;
        end
      end
    end
  end

  a_credit: assert property (@(posedge i_clk) disable iff (i_rst)
    ({1'b0, outstanding} + {1'b0, count}) <= DEPTH_C);
  a_drop: assert property (@(posedge i_clk) disable iff (i_rst)
    drop <= outstanding);
  a_rsp: assert property (@(posedge i_clk) disable iff (i_rst)
    i_ifu_rsp_valid |-> (outstanding != '0));

endmodule
